// File: rtl/nic_pkg.sv
// Shared definitions for the NIC: CPU register map and status word bit positions.
// No ports; imported by the NIC top and the testbench.
package nic_pkg;

    // CPU register select
    typedef enum logic [1:0] {
        NIC_RD_IN  = 2'b00,
        NIC_ST_IN  = 2'b01,
        NIC_WR_OUT = 2'b10,
        NIC_ST_OUT = 2'b11
    } nic_addr_e;

    // Status word layout, shared by both status registers
    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_COUNT_LSB = 2;

    // Sticky flag positions sit just above the count field, so they move with DEPTH
    function automatic int unsigned st_uflow_bit(input int unsigned cnt_w);
        return cnt_w + 2;
    endfunction

    function automatic int unsigned st_oflow_bit(input int unsigned cnt_w);
        return cnt_w + 3;
    endfunction

endpackage

// File: rtl/nic_fifo_if.sv
// NIC bus bundle: CPU register port plus router local-port handshake.
// Modports: master = CPU/router side (drives requests), slave = NIC side.
//   addr, d_in, nicEn, nicEnWR : CPU access
//   d_out                      : CPU read data
//   net_si, net_di, net_ri     : router -> NIC packet, valid/ready
//   net_so, net_do, net_ro     : NIC -> router packet, valid/ready
//   net_polarity               : router phase, injection allowed when 1
interface nic_fifo_if #(
    parameter int unsigned PACKET_WIDTH = 64
);
    logic [1:0]              addr;
    logic [PACKET_WIDTH-1:0] d_in;
    logic [PACKET_WIDTH-1:0] d_out;
    logic                    nicEn;
    logic                    nicEnWR;
    logic                    net_si;
    logic                    net_ri;
    logic [PACKET_WIDTH-1:0] net_di;
    logic                    net_so;
    logic                    net_ro;
    logic [PACKET_WIDTH-1:0] net_do;
    logic                    net_polarity;

    modport master (
        output addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nicEn, nicEnWR, net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/nic_sync_fifo.sv
// Synchronous FIFO with combinational head output and occupancy count.
// Ports: clk, reset (async active-low), push/din, pop, dout (head), full, empty, count.
// A push when full is dropped unless a pop happens on the same edge; a pop when empty
// is dropped (so an empty FIFO with push+pop just takes the push, no bypass).
module nic_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/nic_fifo.sv
// NIC between a CPU port and a router local port, with DEPTH-entry FIFOs each way.
// Ports: clk, reset (async active-low), bus (nic_fifo_if.slave: CPU register access,
// router input handshake net_si/net_ri/net_di, router output net_so/net_ro/net_do,
// net_polarity gating injection).
// Registers: 00 R pop input FIFO, 01 R input status, 10 W push output FIFO, 10 R zero,
// 11 R output status + sticky flags, 11 W clear flags.
module nic_fifo
    import nic_pkg::*;
#(
    parameter int unsigned PACKET_WIDTH = 64,
    parameter int unsigned DEPTH        = 4
) (
    input logic        clk,
    input logic        reset,
    nic_fifo_if.slave  bus
);
    localparam int unsigned CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned UFLOW_BIT = st_uflow_bit(CNT_W);
    localparam int unsigned OFLOW_BIT = st_oflow_bit(CNT_W);

    nic_addr_e               addr;
    logic                    cpu_rd, cpu_wr, send;
    logic                    in_push, in_pop, in_full, in_empty;
    logic                    out_push, out_full, out_empty;
    logic [CNT_W-1:0]        in_count, out_count;
    logic [PACKET_WIDTH-1:0] in_head, out_head, st_in, st_out;
    logic [PACKET_WIDTH-1:0] d_out_q, net_do_q;
    logic                    net_so_q, oflow_q, uflow_q;

    assign addr   = nic_addr_e'(bus.addr);
    assign cpu_rd = bus.nicEn && !bus.nicEnWR;
    assign cpu_wr = bus.nicEn && bus.nicEnWR;

    // Ready depends only on registered occupancy, never on a same-cycle CPU pop
    assign bus.net_ri = !in_full;
    assign in_push    = bus.net_si && !in_full;
    assign in_pop     = cpu_rd && (addr == NIC_RD_IN);

    assign send     = !out_empty && bus.net_ro && bus.net_polarity;
    assign out_push = cpu_wr && (addr == NIC_WR_OUT);

    nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_push),
        .din   (bus.net_di),
        .pop   (in_pop),
        .dout  (in_head),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    nic_sync_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (out_push),
        .din   (bus.d_in),
        .pop   (send),
        .dout  (out_head),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    always_comb begin
        st_in                             = '0;
        st_in[ST_NOT_EMPTY]               = !in_empty;
        st_in[ST_FULL]                    = in_full;
        st_in[ST_COUNT_LSB +: CNT_W]      = in_count;
        st_out                            = '0;
        st_out[ST_NOT_EMPTY]              = !out_empty;
        st_out[ST_FULL]                   = out_full;
        st_out[ST_COUNT_LSB +: CNT_W]     = out_count;
        st_out[UFLOW_BIT]                 = uflow_q;
        st_out[OFLOW_BIT]                 = oflow_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out_q  <= '0;
            net_do_q <= '0;
            net_so_q <= 1'b0;
            oflow_q  <= 1'b0;
            uflow_q  <= 1'b0;
        end else begin
            net_so_q <= send;
            if (send) begin
                net_do_q <= out_head;
            end

            if (cpu_rd) begin
                unique case (addr)
                    NIC_RD_IN: begin
                        d_out_q <= in_empty ? '0 : in_head;
                        if (in_empty) begin
                            uflow_q <= 1'b1;
                        end
                    end
                    NIC_ST_IN:  d_out_q <= st_in;
                    NIC_WR_OUT: d_out_q <= '0;
                    NIC_ST_OUT: d_out_q <= st_out;
                endcase
            end

            // A full FIFO still accepts the write when the same edge sends its head
            if (out_push && out_full && !send) begin
                oflow_q <= 1'b1;
            end
            if (cpu_wr && (addr == NIC_ST_OUT)) begin
                oflow_q <= 1'b0;
                uflow_q <= 1'b0;
            end
        end
    end

    assign bus.d_out  = d_out_q;
    assign bus.net_do = net_do_q;
    assign bus.net_so = net_so_q;
endmodule

// File: tb/tb_nic_fifo.sv
// Self-checking bench for nic_fifo: directed scenarios followed by random traffic,
// checked against a queue-based model through a scoreboard.
module tb_nic_fifo;
    import nic_pkg::*;

    localparam int unsigned W     = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nic_fifo_if #(.PACKET_WIDTH(W)) bus ();

    nic_fifo #(.PACKET_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    bit           ovf = 1'b0;
    bit           unf = 1'b0;
    // Scoreboard
    logic [W-1:0] exp_rd[$];
    logic [W-1:0] exp_tx[$];
    bit           rd_seen = 1'b0;
    bit           tx_seen = 1'b0;
    bit           exp_ri  = 1'b1;
    // Model scratch
    bit           m_rd, m_wr, m_snd;
    int           m_in_n, m_out_n;
    logic [W-1:0] m_v;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: one step per rising edge, using the pre-edge contents.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_q.delete();
            out_q.delete();
            exp_rd.delete();
            exp_tx.delete();
            ovf     = 1'b0;
            unf     = 1'b0;
            rd_seen = 1'b0;
            tx_seen = 1'b0;
            exp_ri  = 1'b1;
        end else begin
            m_in_n  = in_q.size();
            m_out_n = out_q.size();
            m_rd    = bus.nicEn && !bus.nicEnWR;
            m_wr    = bus.nicEn && bus.nicEnWR;
            m_snd   = (m_out_n > 0) && bus.net_ro && bus.net_polarity;
            rd_seen = m_rd;
            if (m_rd) begin
                m_v = '0;
                case (bus.addr)
                    2'b00: begin
                        if (m_in_n == 0) unf = 1'b1;
                        else m_v = in_q.pop_front();
                    end
                    2'b01: m_v = W'(m_in_n) * 4 + W'(m_in_n == DEPTH) * 2 + W'(m_in_n != 0);
                    2'b10: m_v = '0;
                    default: m_v = W'(m_out_n) * 4 + W'(m_out_n == DEPTH) * 2
                                 + W'(m_out_n != 0) + W'(unf) * (64'd1 << (CNT_W + 2))
                                 + W'(ovf) * (64'd1 << (CNT_W + 3));
                endcase
                exp_rd.push_back(m_v);
            end
            tx_seen = m_snd;
            if (m_snd) exp_tx.push_back(out_q.pop_front());
            if (m_wr && bus.addr == 2'b10) begin
                if (m_out_n == DEPTH && !m_snd) ovf = 1'b1;
                else out_q.push_back(bus.d_in);
            end
            if (m_wr && bus.addr == 2'b11) begin
                ovf = 1'b0;
                unf = 1'b0;
            end
            if (bus.net_si && m_in_n < DEPTH) in_q.push_back(bus.net_di);
            exp_ri = (in_q.size() < DEPTH);
        end
    end

    // Monitor: sample on the falling edge, compare whatever the DUT presents.
    always @(negedge clk) begin
        if (reset) begin
            check("net_ri", W'(bus.net_ri), W'(exp_ri));
            check("net_so", W'(bus.net_so), W'(tx_seen));
            if (bus.net_so) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL net_do: got %h, expected no packet", bus.net_do);
                end else begin
                    check("net_do", bus.net_do, exp_tx.pop_front());
                end
            end
            if (rd_seen) begin
                if (exp_rd.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL d_out: got %h, expected no read", bus.d_out);
                end else begin
                    check("d_out", bus.d_out, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit en, input bit wr, input logic [1:0] a, input logic [W-1:0] din,
                         input bit si, input logic [W-1:0] di, input bit ro, input bit pol);
        bus.nicEn        = en;
        bus.nicEnWR      = wr;
        bus.addr         = a;
        bus.d_in         = din;
        bus.net_si       = si;
        bus.net_di       = di;
        bus.net_ro       = ro;
        bus.net_polarity = pol;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 2'b00, '0, 0, '0, 0, 0);
    endtask

    task automatic cpu_rd(input logic [1:0] a);
        drive(1, 0, a, '0, 0, '0, 0, 0);
    endtask

    task automatic cpu_wr(input logic [1:0] a, input logic [W-1:0] v, input bit ro, input bit pol);
        drive(1, 1, a, v, 0, '0, ro, pol);
    endtask

    initial begin
        bus.nicEn = 0; bus.nicEnWR = 0; bus.addr = 0; bus.d_in = 0;
        bus.net_si = 0; bus.net_di = 0; bus.net_ro = 0; bus.net_polarity = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_net_ri", W'(bus.net_ri), W'(1));
        check("rst_net_so", W'(bus.net_so), W'(0));
        check("rst_d_out", bus.d_out, '0);
        check("rst_net_do", bus.net_do, '0);
        reset = 1'b1;
        cpu_rd(NIC_ST_OUT);

        // Input fill: 5th packet refused
        for (int i = 1; i <= 5; i++) drive(0, 0, 2'b00, '0, 1, W'(i), 0, 0);
        cpu_rd(NIC_ST_IN);
        for (int i = 0; i < 4; i++) cpu_rd(NIC_RD_IN);

        // All-zero packet is a real entry
        drive(0, 0, 2'b00, '0, 1, '0, 0, 0);
        cpu_rd(NIC_ST_IN);
        cpu_rd(NIC_RD_IN);
        cpu_rd(NIC_ST_IN);

        // Polarity gating and backpressure
        cpu_wr(NIC_WR_OUT, 64'hAA, 0, 0);
        cpu_wr(NIC_WR_OUT, 64'hBB, 0, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 2'b00, '0, 0, '0, 1, i[0]);
        cpu_wr(NIC_WR_OUT, 64'hDD, 0, 1);
        idle(2);
        drive(0, 0, 2'b00, '0, 0, '0, 1, 1);

        // Overflow / underflow / clear
        for (int i = 0; i < 5; i++) cpu_wr(NIC_WR_OUT, W'(16 + i), 0, 0);
        cpu_rd(NIC_ST_OUT);
        cpu_rd(NIC_RD_IN);
        cpu_rd(NIC_ST_OUT);
        cpu_wr(NIC_ST_OUT, '0, 0, 0);
        cpu_rd(NIC_ST_OUT);

        // Full output FIFO with a send on the same edge as a write
        cpu_wr(NIC_WR_OUT, 64'hCC, 1, 1);
        cpu_rd(NIC_ST_OUT);
        for (int i = 0; i < 6; i++) drive(0, 0, 2'b00, '0, 0, '0, 1, 1);
        cpu_rd(NIC_ST_OUT);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, $urandom_range(0, 2) != 0, {$urandom, $urandom},
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1));
        end
        idle(2);

        // Reset mid-transfer: net_so must drop without waiting for a clock
        cpu_wr(NIC_WR_OUT, 64'h55, 0, 0);
        drive(0, 0, 2'b00, '0, 0, '0, 1, 1);
        check("pre_rst_net_so", W'(bus.net_so), W'(1));
        reset = 1'b0;
        #1;
        check("async_net_so", W'(bus.net_so), W'(0));
        check("async_net_do", bus.net_do, '0);
        check("async_net_ri", W'(bus.net_ri), W'(1));
        idle(1);
        reset = 1'b1;
        cpu_rd(NIC_ST_OUT);
        cpu_rd(NIC_ST_IN);
        idle(3);

        check("rd_left", W'(exp_rd.size()), '0);
        check("tx_left", W'(exp_tx.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
